// File: rtl/mux_operation_axil_slave.sv
// ============================================================================
// Module  : mux_operation_axil_slave
// Purpose : AXI4-Lite register slave with a registered ALU/mux result.
//           Optional macro MUX_OPERATION_WSTRB_EN enables byte-strobe writes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_operation_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   result_o
);

  localparam int DW = C_S_AXI_DATA_WIDTH;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} wstate_t;
  typedef enum logic [0:0] {R_IDLE, R_DATA} rstate_t;

  wstate_t       r_wstate;
  rstate_t       r_rstate;
  logic          r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
  logic [1:0]    r_bresp;
  logic [1:0]    r_awaddr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_opa, r_opb, r_result, r_rdata;
  logic [2:0]    r_ctrl;

  logic          w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic [1:0]    w_caddr;
  logic [DW-1:0] w_cdata, w_new, w_alu, w_rd_mux;

  assign w_aw_hs = s00_axi_awvalid & r_awready;
  assign w_w_hs  = s00_axi_wvalid  & r_wready;
  assign w_ar_hs = s00_axi_arvalid & r_arready;

`ifdef MUX_OPERATION_WSTRB_EN
  logic [DW/8-1:0] r_wstrb;
  logic [DW/8-1:0] w_cstrb;
  logic [DW-1:0]   w_cur;
  logic            w_unused;
  assign w_unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};
`else
  logic w_unused;
  assign w_unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0],
                      s00_axi_wstrb};
`endif

  // Commit sources: address/data come from the latch for whichever half arrived first.
  always_comb begin
    w_commit = 1'b0;
    case (r_wstate)
      W_IDLE:      w_commit = w_aw_hs & w_w_hs;
      W_HAVE_ADDR: w_commit = w_w_hs;
      W_HAVE_DATA: w_commit = w_aw_hs;
      default:     w_commit = 1'b0;
    endcase
    w_caddr = (r_wstate == W_HAVE_ADDR) ? r_awaddr : s00_axi_awaddr[3:2];
    w_cdata = (r_wstate == W_HAVE_DATA) ? r_wdata  : s00_axi_wdata;
`ifdef MUX_OPERATION_WSTRB_EN
    w_cstrb = (r_wstate == W_HAVE_DATA) ? r_wstrb  : s00_axi_wstrb;
    case (w_caddr)
      2'd0:    w_cur = r_opa;
      2'd1:    w_cur = r_opb;
      2'd2:    w_cur = {{(DW-3){1'b0}}, r_ctrl};
      default: w_cur = '0;
    endcase
    for (int i = 0; i < DW/8; i++) begin
      w_new[i*8 +: 8] = w_cstrb[i] ? w_cdata[i*8 +: 8] : w_cur[i*8 +: 8];
    end
`else
    w_new = w_cdata;
`endif
  end

  always_comb begin
    w_alu = '0;
    case (r_ctrl)
      3'd0: w_alu = r_opa + r_opb;
      3'd1: w_alu = r_opa - r_opb;
      3'd2: w_alu = r_opa & r_opb;
      3'd3: w_alu = r_opa | r_opb;
      3'd4: w_alu = r_opa ^ r_opb;
      3'd5: w_alu = r_opa;
      3'd6: w_alu = r_opb;
      3'd7: w_alu = r_opb[0] ? r_opa : '0;
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_rd_mux = '0;
    case (s00_axi_araddr[3:2])
      2'd0:    w_rd_mux = r_opa;
      2'd1:    w_rd_mux = r_opb;
      2'd2:    w_rd_mux = {{(DW-3){1'b0}}, r_ctrl};
      default: w_rd_mux = r_result;
    endcase
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      r_awaddr  <= '0;
      r_wdata   <= '0;
`ifdef MUX_OPERATION_WSTRB_EN
      r_wstrb   <= '0;
`endif
      r_opa     <= '0;
      r_opb     <= '0;
      r_ctrl    <= '0;
      r_result  <= '0;
    end else begin
      r_result <= w_alu;
      case (r_wstate)
        W_IDLE: begin
          r_awready <= 1'b1;
          r_wready  <= 1'b1;
          if (w_aw_hs && !w_w_hs) begin
            r_awaddr  <= s00_axi_awaddr[3:2];
            r_awready <= 1'b0;
            r_wstate  <= W_HAVE_ADDR;
          end else if (w_w_hs && !w_aw_hs) begin
            r_wdata  <= s00_axi_wdata;
`ifdef MUX_OPERATION_WSTRB_EN
            r_wstrb  <= s00_axi_wstrb;
`endif
            r_wready <= 1'b0;
            r_wstate <= W_HAVE_DATA;
          end
        end
        W_RESP: begin
          if (s00_axi_bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: ;
      endcase
      if (w_commit) begin
        r_wstate  <= W_RESP;
        r_awready <= 1'b0;
        r_wready  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= (w_caddr == 2'd3) ? 2'b10 : 2'b00;
        case (w_caddr)
          2'd0:    r_opa  <= w_new;
          2'd1:    r_opb  <= w_new;
          2'd2:    r_ctrl <= w_new[2:0];
          default: ;
        endcase
      end
    end
  end

  // rdata is captured from pre-edge register values, so a same-cycle write is not visible.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          r_arready <= 1'b1;
          if (w_ar_hs) begin
            r_rdata   <= w_rd_mux;
            r_rvalid  <= 1'b1;
            r_arready <= 1'b0;
            r_rstate  <= R_DATA;
          end
        end
        default: begin
          if (s00_axi_rready) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end
        end
      endcase
    end
  end

  assign s00_axi_awready = r_awready;
  assign s00_axi_wready  = r_wready;
  assign s00_axi_bvalid  = r_bvalid;
  assign s00_axi_bresp   = r_bresp;
  assign s00_axi_arready = r_arready;
  assign s00_axi_rvalid  = r_rvalid;
  assign s00_axi_rdata   = r_rdata;
  assign s00_axi_rresp   = 2'b00;
  assign result_o        = r_result;

endmodule

`default_nettype wire

// File: tb/tb_mux_operation_axil_slave.sv
// ============================================================================
// Module  : tb_mux_operation_axil_slave
// Purpose : Directed and randomized bench for mux_operation_axil_slave.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_operation_axil_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata, result;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_reg [4];

  always #5 clk = ~clk;

  mux_operation_axil_slave dut (
    .s00_axi_aclk(clk), .s00_axi_areset(rst),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
    .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
    .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
    .s00_axi_rready(rready), .result_o(result)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] m_res();
    logic [31:0] a = m_reg[0];
    logic [31:0] b = m_reg[1];
    case (m_reg[2][2:0])
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a;
      3'd6: return b;
      default: return b[0] ? a : 32'h0;
    endcase
  endfunction

  function automatic void m_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] v;
    if (a[3:2] == 2'd3) return;
    v = m_reg[a[3:2]];
`ifdef MUX_OPERATION_WSTRB_EN
    for (int i = 0; i < 4; i++) if (s[i]) v[i*8 +: 8] = d[i*8 +: 8];
`else
    v = d;
    if (s === 4'hx) v = d;
`endif
    if (a[3:2] == 2'd2) v = v & 32'h7;
    m_reg[a[3:2]] = v;
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] a);
    return (a[3:2] == 2'd3) ? m_res() : m_reg[a[3:2]];
  endfunction

  task automatic idle_inputs();
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    awaddr = 0; araddr = 0; wdata = 0; wstrb = 4'hF; awprot = 0; arprot = 0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int aw_dly, input int w_dly, input int b_dly);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int cyc = 0;
    logic [1:0] resp;
    awaddr = a; wdata = d; wstrb = s;
    while (!(aw_done && w_done) && cyc < 40) begin
      awvalid = !aw_done && cyc >= aw_dly;
      wvalid  = !w_done  && cyc >= w_dly;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      tick();
      cyc++;
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done  = 1;
      if (aw_done && !w_done) chk("awready_after_aw", awready, 0);
      if (w_done && !aw_done) chk("wready_after_w", wready, 0);
    end
    awvalid = 0; wvalid = 0;
    if (!(aw_done && w_done)) chk("write_accept_timeout", 0, 1);
    cyc = 0;
    while (!bvalid && cyc < 20) begin tick(); cyc++; end
    chk("bvalid", bvalid, 1);
    resp = bresp;
    chk("bresp", resp, (a[3:2] == 2'd3) ? 2'b10 : 2'b00);
    m_write(a, d, s);
    repeat (b_dly) begin
      tick();
      chk("bvalid_hold", bvalid, 1);
      chk("aw_blocked_in_resp", awready, 0);
    end
    bready = 1;
    tick();
    bready = 0;
    chk("bvalid_clear", bvalid, 0);
    tick();
    chk("result_o", result, m_res());
  endtask

  task automatic rd(input logic [3:0] a, input int r_dly);
    int cyc = 0;
    logic [31:0] exp = m_read(a);
    arvalid = 1; araddr = a;
    while (!arready && cyc < 20) begin tick(); cyc++; end
    if (!arready) chk("arready_timeout", 0, 1);
    tick();
    arvalid = 0;
    chk("rvalid_latency", rvalid, 1);
    chk($sformatf("rdata@%0h", a), rdata, exp);
    chk("rresp", rresp, 0);
    repeat (r_dly) begin
      tick();
      chk("rvalid_hold", rvalid, 1);
      chk("rdata_hold", rdata, exp);
    end
    rready = 1;
    tick();
    rready = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    repeat (3) tick();
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_result", result, 0);
    for (int i = 0; i < 4; i++) m_reg[i] = 0;
    rst = 0;
    tick();
    chk("post_rst_awready", awready, 1);
    chk("post_rst_wready", wready, 1);
    chk("post_rst_arready", arready, 1);
  endtask

  initial begin
    logic [31:0] old_v;
    do_reset();

    wr(4'h0, 32'h5, 4'hF, 0, 0, 0);
    wr(4'h4, 32'h3, 4'hF, 0, 0, 0);
    wr(4'h8, 32'h0, 4'hF, 0, 0, 0);
    rd(4'hC, 0);
    chk("add_result", m_read(4'hC), 32'h8);

    wr(4'h0, 32'h3, 4'hF, 0, 0, 0);
    wr(4'h4, 32'h5, 4'hF, 0, 0, 0);
    wr(4'h8, 32'h1, 4'hF, 0, 0, 0);
    rd(4'hC, 0);
    wr(4'h8, 32'hFFFFFFFC, 4'hF, 0, 0, 0);
    rd(4'h8, 0);
    rd(4'hC, 0);

    wr(4'h4, 32'hA5A5A5A5, 4'hF, 0, 3, 0);
    rd(4'h4, 0);
    wr(4'h5, 32'h5A5A5A5A, 4'hF, 3, 0, 0);
    rd(4'h4, 0);

    wr(4'h0, 32'h12345678, 4'hF, 0, 0, 5);
    rd(4'h0, 5);

    old_v = m_res();
    wr(4'hC, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    rd(4'hC, 0);
    chk("result_unchanged", m_read(4'hC), old_v);

    // Read of RESULT one cycle after an operand commit must return the old result.
    wr(4'h8, 32'h0, 4'hF, 0, 0, 0);
    old_v = m_res();
    awaddr = 4'h0; wdata = 32'h00000100; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0; araddr = 4'hC; arvalid = 1;
    tick();
    arvalid = 0;
    chk("result_commit_plus1", rdata, old_v);
    m_write(4'h0, 32'h00000100, 4'hF);
    rready = 1; bready = 1;
    tick();
    rready = 0; bready = 0;
    rd(4'hC, 0);

    // Same-cycle read and write of OPB: read sees the pre-write value.
    old_v = m_reg[1];
    awaddr = 4'h4; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 4'h4; arvalid = 1;
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk("same_cycle_read", rdata, old_v);
    m_write(4'h4, 32'hCAFEF00D, 4'hF);
    rready = 1; bready = 1;
    tick();
    rready = 0; bready = 0;
    rd(4'h4, 0);

    // Reset while a write address is held without data.
    awaddr = 4'h0; awvalid = 1;
    tick();
    awvalid = 0;
    chk("have_addr_awready", awready, 0);
    do_reset();
    wvalid = 1; wdata = 32'hFFFFFFFF;
    wvalid = 0;
    rd(4'h0, 0);
    rd(4'hC, 0);

    wr(4'h0, 32'h11223344, 4'hF, 0, 0, 0);
    wr(4'h0, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
`ifdef MUX_OPERATION_WSTRB_EN
    chk("wstrb_model", m_reg[0], 32'h11BB33DD);
`else
    chk("wstrb_model", m_reg[0], 32'hAABBCCDD);
`endif
    rd(4'h0, 0);

    for (int it = 0; it < 60; it++) begin
      logic [3:0] a;
      a = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0)
        wr(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
           $urandom_range(0, 3), $urandom_range(0, 2));
      else
        rd(a, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
